// File: rtl/trojan1_pipelined_fsm_host.sv
// Handshaked multi-stage word processor hosting Trojan1; r1 comes from an LFSR,
// trigger is folded into the final-stage result. One word in flight at a time.

module Trojan1 (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);
  logic [3:0] hist_q, hist_d;
  logic       trig_q, trig_d;

  // Fires one cycle after the r1 history shows the 1010 pattern.
  always_comb begin
    hist_d = {hist_q[2:0], r1};
    trig_d = (hist_d == 4'b1010);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 4'd0;
      trig_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      trig_q <= trig_d;
    end
  end

  assign trigger = trig_q;
endmodule

module trojan1_pipelined_fsm_host #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            NUM_STAGES = 3,
  parameter int unsigned            LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0]  INIT_SEED  = 8'hA5,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_TAPS  = 8'h88
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mode,
  input  logic                  hold,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic [3:0]            stage_idx,
  output logic [15:0]           done_count
);
  typedef enum logic [1:0] {IDLE, PROC, OUTPUT} state_e;

  localparam logic [DATA_WIDTH-1:0] HALF_MASK = {DATA_WIDTH{1'b1}} >> 1;
  localparam logic [DATA_WIDTH-1:0] ONE       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]            LAST_IDX  = 4'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_reg_q, data_reg_d;
  logic                  mode_q, mode_d;
  logic [3:0]            stage_idx_q, stage_idx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [15:0]           done_count_q, done_count_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  logic                  trojan_r1;
  logic                  trojan_trigger;
  logic [3:0]            k_mod3;
  logic [DATA_WIDTH-1:0] op_res;

  Trojan1 u_trojan1 (
    .clk     (clk),
    .rst     (rst),
    .r1      (trojan_r1),
    .trigger (trojan_trigger)
  );

  assign trojan_r1 = lfsr_q[0];
  assign k_mod3    = stage_idx_q % 4'd3;

  always_comb begin
    op_res = data_reg_q;
    case (k_mod3)
      4'd0:    op_res = data_reg_q + ONE;
      4'd1:    op_res = data_reg_q ^ HALF_MASK;
      default: op_res = mode_q ? {data_reg_q[DATA_WIDTH-2:0], data_reg_q[DATA_WIDTH-1]}
                               : {data_reg_q[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_reg_d   = data_reg_q;
    mode_d       = mode_q;
    stage_idx_d  = stage_idx_q;
    data_out_d   = data_out_q;
    done_count_d = done_count_q;
    lfsr_d       = lfsr_q;

    // LFSR advances on every unstalled PROC cycle, including an aborting one.
    if (state_q == PROC && !hold) begin
      lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_reg_d  = data_in;
          mode_d      = mode;
          stage_idx_d = 4'd0;
          state_d     = PROC;
        end
      end
      PROC: begin
        if (abort) begin
          stage_idx_d = 4'd0;
          state_d     = IDLE;
        end else if (!hold) begin
          if (stage_idx_q == LAST_IDX) begin
            data_out_d  = op_res ^ {DATA_WIDTH{trojan_trigger}};
            stage_idx_d = 4'd0;
            state_d     = OUTPUT;
          end else begin
            data_reg_d  = op_res;
            stage_idx_d = stage_idx_q + 4'd1;
          end
        end
      end
      OUTPUT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_reg_q   <= '0;
      mode_q       <= 1'b0;
      stage_idx_q  <= 4'd0;
      data_out_q   <= '0;
      done_count_q <= 16'd0;
      lfsr_q       <= INIT_SEED;
    end else begin
      state_q      <= state_d;
      data_reg_q   <= data_reg_d;
      mode_q       <= mode_d;
      stage_idx_q  <= stage_idx_d;
      data_out_q   <= data_out_d;
      done_count_q <= done_count_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == OUTPUT);
  assign data_out   = data_out_q;
  assign stage_idx  = stage_idx_q;
  assign done_count = done_count_q;
endmodule

// File: tb/tb_trojan1_pipelined_fsm_host.sv
// Directed bench: default 8-bit/3-stage instance plus a 16-bit/1-stage instance.
module tb_trojan1_pipelined_fsm_host;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_mode, a_hold, a_abort;
  logic        a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_data_in, a_data_out;
  logic [3:0]  a_stage_idx;
  logic [15:0] a_done_count;

  logic        b_in_valid, b_in_ready, b_mode, b_hold, b_abort;
  logic        b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_data_in, b_data_out;
  logic [3:0]  b_stage_idx;
  logic [15:0] b_done_count;

  trojan1_pipelined_fsm_host dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .mode(a_mode), .hold(a_hold), .abort(a_abort),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
    .busy(a_busy), .stage_idx(a_stage_idx), .done_count(a_done_count)
  );

  trojan1_pipelined_fsm_host #(.DATA_WIDTH(16), .NUM_STAGES(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .mode(b_mode), .hold(b_hold), .abort(b_abort),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
    .busy(b_busy), .stage_idx(b_stage_idx), .done_count(b_done_count)
  );

  typedef struct {
    logic [7:0] din;
    logic       mode;
    logic       trig;
    logic [7:0] mid1;
    logic [7:0] mid2;
    logic [7:0] dout;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_a_done = 16'd0;
  logic [15:0] exp_b_done = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input vec_t v);
    int edges;
    if (v.trig) force dut.u_trojan1.trig_q = 1'b1;
    else        force dut.u_trojan1.trig_q = 1'b0;
    check("in_ready_before", a_in_ready, 1);
    a_data_in = v.din; a_mode = v.mode; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_data_in = 8'h00; a_mode = ~v.mode;
    edges = 1;
    check("busy_after_accept", a_busy, 1);
    while (!a_out_valid && edges < 20) begin
      tick();
      edges++;
      if (edges == 2) check("data_reg_stage0", dut.data_reg_q, v.mid1);
      if (edges == 3) check("data_reg_stage1", dut.data_reg_q, v.mid2);
    end
    check("latency_edges", edges, 4);
    check("data_out", a_data_out, v.dout);
    tick();
    check("out_valid_held", a_out_valid, 1);
    check("data_out_stable", a_data_out, v.dout);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    exp_a_done++;
    check("done_count", a_done_count, exp_a_done);
    check("idle_after_handshake", a_busy, 0);
    force dut.u_trojan1.trig_q = 1'b0;
  endtask

  task automatic run_b(input logic [15:0] din, input logic [15:0] dout);
    b_data_in = din; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("b_ov_after_accept", b_out_valid, 0);
    tick();
    check("b_latency2_ov", b_out_valid, 1);
    check("b_data_out", b_data_out, dout);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    exp_b_done++;
    check("b_done_count", b_done_count, exp_b_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hC0, 1'b0, 1'b0, 8'hC1, 8'hBE, 8'h7C};
    vecs[1] = '{8'hC0, 1'b1, 1'b0, 8'hC1, 8'hBE, 8'h7D};
    vecs[2] = '{8'hC0, 1'b0, 1'b1, 8'hC1, 8'hBE, 8'h83};
    vecs[3] = '{8'h3F, 1'b1, 1'b0, 8'h40, 8'h3F, 8'h7E};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 8'h7F, 8'hFE};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h81, 8'hFE, 8'h02};

    force dut.u_trojan1.trig_q   = 1'b0;
    force dut16.u_trojan1.trig_q = 1'b0;
    rst = 1'b1;
    a_in_valid = 0; a_mode = 0; a_hold = 0; a_abort = 0; a_out_ready = 0; a_data_in = 0;
    b_in_valid = 0; b_mode = 0; b_hold = 0; b_abort = 0; b_out_ready = 0; b_data_in = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_in_ready", a_in_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_data_out", a_data_out, 0);
    check("rst_stage_idx", a_stage_idx, 0);
    check("rst_done_count", a_done_count, 0);
    check("rst_lfsr", dut.lfsr_q, 8'hA5);
    check("rst_data_reg", dut.data_reg_q, 0);

    // LFSR stepping and hold freeze, in_valid left high throughout
    a_data_in = 8'hC0; a_mode = 1'b0; a_in_valid = 1'b1;
    check("r1_seed", dut.trojan_r1, 1);
    tick();
    check("lfsr_at_accept", dut.lfsr_q, 8'hA5);
    check("stage_at_accept", a_stage_idx, 0);
    tick();
    check("lfsr_step1", dut.lfsr_q, 8'h4B);
    check("r1_step1", dut.trojan_r1, 1);
    check("stage_step1", a_stage_idx, 1);
    a_hold = 1'b1;
    tick(); tick();
    check("lfsr_hold", dut.lfsr_q, 8'h4B);
    check("stage_hold", a_stage_idx, 1);
    check("data_reg_hold", dut.data_reg_q, 8'hC1);
    check("ov_during_hold", a_out_valid, 0);
    a_hold = 1'b0;
    tick();
    check("lfsr_step2", dut.lfsr_q, 8'h97);
    check("r1_step2", dut.trojan_r1, 1);
    check("stage_step2", a_stage_idx, 2);
    check("data_reg_step2", dut.data_reg_q, 8'hBE);
    check("ov_edge5", a_out_valid, 0);
    tick();
    check("ov_edge6", a_out_valid, 1);
    check("hold_data_out", a_data_out, 8'h7C);
    check("stage_in_output", a_stage_idx, 0);
    check("in_ready_output", a_in_ready, 0);
    check("lfsr_step3", dut.lfsr_q, 8'h2F);
    a_out_ready = 1'b1;
    tick();
    exp_a_done++;
    check("no_accept_on_handshake", a_busy, 0);
    check("done_after_hold_word", a_done_count, exp_a_done);
    a_in_valid = 1'b0; a_out_ready = 1'b0;

    // Abort at stage 1, with hold also asserted
    a_data_in = 8'h55; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    check("pre_abort_stage", a_stage_idx, 1);
    a_abort = 1'b1; a_hold = 1'b1;
    tick();
    a_abort = 1'b0; a_hold = 1'b0;
    check("abort_proc_busy", a_busy, 0);
    check("abort_proc_ov", a_out_valid, 0);
    check("abort_proc_stage", a_stage_idx, 0);
    check("abort_proc_data_out", a_data_out, 8'h7C);
    check("abort_proc_done", a_done_count, exp_a_done);

    for (int i = 0; i < 6; i++) run_word(vecs[i]);

    // Abort during OUTPUT beats out_ready
    a_data_in = 8'hC0; a_mode = 1'b1; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    check("abort_out_pre_ov", a_out_valid, 1);
    check("abort_out_pre_data", a_data_out, 8'h7D);
    a_abort = 1'b1; a_out_ready = 1'b1;
    tick();
    a_abort = 1'b0; a_out_ready = 1'b0;
    check("abort_out_ov", a_out_valid, 0);
    check("abort_out_done", a_done_count, exp_a_done);
    check("abort_out_data_kept", a_data_out, 8'h7D);

    // Abort in IDLE is ignored; the accept proceeds
    a_data_in = 8'hC0; a_mode = 1'b0; a_in_valid = 1'b1; a_abort = 1'b1;
    tick();
    a_in_valid = 1'b0; a_abort = 1'b0;
    check("abort_idle_accept", a_busy, 1);
    tick(); tick(); tick();
    check("abort_idle_ov", a_out_valid, 1);
    check("abort_idle_data", a_data_out, 8'h7C);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    exp_a_done++;
    check("abort_idle_done", a_done_count, exp_a_done);

    // 16-bit, single-stage instance
    run_b(16'hFFFF, 16'h0000);
    run_b(16'h1234, 16'h1235);
    force dut16.done_count_q = 16'hFFFF;
    tick();
    release dut16.done_count_q;
    exp_b_done = 16'hFFFF;
    run_b(16'h0001, 16'h0002);
    run_b(16'h00FF, 16'h0100);

    b_data_in = 16'h4321; b_in_valid = 1'b1; b_hold = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    check("b_busy_mid_proc", b_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; b_hold = 1'b0;
    check("b_rst_busy", b_busy, 0);
    check("b_rst_in_ready", b_in_ready, 1);
    check("b_rst_out_valid", b_out_valid, 0);
    check("b_rst_data_out", b_data_out, 0);
    check("b_rst_stage", b_stage_idx, 0);
    check("b_rst_done", b_done_count, 0);
    check("b_rst_lfsr", dut16.lfsr_q, 8'hA5);
    check("b_rst_data_reg", dut16.data_reg_q, 0);
    check("a_rst_done", a_done_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
